// File: rtl/pret_pkg.sv
// Shared types and helpers for the pret_et progressive-precision stochastic engine.
package pret_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reverse the low w bits of v (w <= 32); upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input logic [31:0] w);
    logic [31:0] full;
    for (int i = 0; i < 32; i++) begin
      full[i] = v[31-i];
    end
    return full >> (32'd32 - w);
  endfunction

  // Limit a requested precision to the legal range 1..w.
  function automatic logic [31:0] clamp_prec(input logic [31:0] p, input logic [31:0] w);
    if (p < 32'd1) return 32'd1;
    if (p > w)     return w;
    return p;
  endfunction

endpackage

// File: rtl/pret_seq.sv
// Cycle sequencer: cycle counter c, its bit-reversed low-discrepancy threshold r,
// the constant-0.5 streams, and detection of power-of-two job lengths
// (n = c + 1 = 2^k) with k encoded from the one-hot n.
module pret_seq
  import pret_pkg::*;
#(
  parameter int W  = 8,
  parameter int NC = 1,
  parameter int PW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [W-1:0]  r,
  output logic [NC-1:0] xcs,
  output logic          boundary,
  output logic [PW-1:0] k
);

  logic [W:0] c;
  logic [W:0] n;

  assign n        = c + (W + 1)'(1);
  assign boundary = (n != '0) && ((n & (n - (W + 1)'(1))) == '0);
  assign r        = W'(bitrev(32'(c[W-1:0]), 32'(W)));
  assign xcs      = enable ? c[NC-1:0] : '0;

  // Encode the exponent of the one-hot cycle count.
  always_comb begin
    k = '0;
    for (int i = 0; i <= W; i++) begin
      if (n[i]) k = PW'(i);
    end
  end

  // Cycle counter: cleared at job accept, advanced once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         c <= '0;
    else if (clear)  c <= '0;
    else if (enable) c <= c + (W + 1)'(1);
  end

endmodule

// File: rtl/pret_et.sv
// pret_et: job-based progressive-precision stochastic bitstream engine.
// Drives N low-discrepancy operand streams and NC constant-0.5 streams into an
// external SC circuit, counts its output Z and returns a W-bit-normalised result
// when the precision limit is reached.
// Define PRET_ET_EN to enable the early-termination convergence check; without
// it every job runs exactly 2^p cycles and tol is ignored.
module pret_et
  import pret_pkg::*;
#(
  parameter int W      = 8,
  parameter int N      = 2,
  parameter int NC     = 1,
  parameter int ET_MIN = 2,
  localparam int PW    = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] Bxs,
  input  logic [PW-1:0]  prec,
  input  logic [W-1:0]   tol,
  output logic [N-1:0]   Xs,
  output logic [NC-1:0]  Xcs,
  input  logic           Z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     Bz,
  output logic [PW-1:0]  k_out
);

  state_t          state;
  logic [N*W-1:0]  bx;
  logic [PW-1:0]   p;
  logic [W:0]      cnt;
  logic [W:0]      nxt;
  logic [W:0]      scaled;
  logic [PW:0]     sh;
  logic [W-1:0]    r;
  logic [PW-1:0]   k;
  logic            boundary;
  logic            accept;
  logic            run;
  logic            et_stop;
  logic            finish;

  assign accept = in_ready & in_valid;
  assign run    = (state == RUN);
  assign nxt    = cnt + (W + 1)'(Z);
  // Scale the count over 2^k cycles up to the 2^W full-scale range.
  assign sh     = (PW + 1)'(W) - (PW + 1)'(k);
  assign scaled = nxt << sh;
  assign finish = run && boundary && ((k == p) || et_stop);

  pret_seq #(
    .W  (W),
    .NC (NC),
    .PW (PW)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (run),
    .r        (r),
    .xcs      (Xcs),
    .boundary (boundary),
    .k        (k)
  );

  // Operand streams: each operand compared against the shared bit-reversed threshold.
  always_comb begin
    Xs = '0;
    if (run) begin
      for (int i = 0; i < N; i++) begin
        Xs[i] = (bx[i*W +: W] > r);
      end
    end
  end

  // Job parameters are plain data, captured at accept without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bx <= Bxs;
      p  <= PW'(clamp_prec(32'(prec), 32'(W)));
    end
  end

`ifdef PRET_ET_EN
  logic [W-1:0] tol_q;
  logic [W:0]   prev;
  logic [W+1:0] cur_s;
  logic [W+1:0] prev_s;
  logic [W+1:0] diff;

  // prev holds the count at the previous boundary (half as many cycles), so it
  // scales by one extra bit to land on the same full-scale range.
  assign cur_s   = {1'b0, nxt} << sh;
  assign prev_s  = {1'b0, prev} << (sh + (PW + 1)'(1));
  assign diff    = (cur_s >= prev_s) ? (cur_s - prev_s) : (prev_s - cur_s);
  assign et_stop = (k >= PW'(ET_MIN)) && (diff <= {2'b00, tol_q});

  // Tolerance latch for the convergence check.
  always_ff @(posedge clk) begin
    if (accept) tol_q <= tol;
  end

  // Snapshot of the running count at every power-of-two boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  prev <= '0;
    else if (accept)          prev <= '0;
    else if (run && boundary) prev <= nxt;
  end
`else
  logic unused_tol;

  assign unused_tol = ^tol;
  assign et_stop    = 1'b0;
`endif

  // Job FSM with registered handshake outputs, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      Bz        <= '0;
      k_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            cnt      <= '0;
          end
        end
        RUN: begin
          cnt <= nxt;
          if (finish) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Bz        <= scaled;
            k_out     <= k;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pret_et.sv
// Directed bench for pret_et (W=8, N=2, NC=1). Expected values are hand-derived;
// where early termination changes the outcome, both builds' values are listed.
module tb_pret_et;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int NC = 1;
  localparam int PW = 4;
`ifdef PRET_ET_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  // Reset lands mid-RUN; with early termination the job would end at cycle 4.
  localparam int RST_AT = ET ? 2 : 50;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] Bxs;
  logic [PW-1:0]  prec;
  logic [W-1:0]   tol;
  logic [N-1:0]   Xs;
  logic [NC-1:0]  Xcs;
  logic           Z;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     Bz;
  logic [PW-1:0]  k_out;
  logic           zm;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // SC circuit: zm=0 -> AND of both streams, zm=1 -> pass stream 0.
  assign Z = zm ? Xs[0] : (Xs[0] & Xs[1]);

  pret_et #(
    .W      (W),
    .N      (N),
    .NC     (NC),
    .ET_MIN (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Bxs       (Bxs),
    .prec      (prec),
    .tol       (tol),
    .Xs        (Xs),
    .Xcs       (Xcs),
    .Z         (Z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Bz        (Bz),
    .k_out     (k_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One job: accept, check first two stream cycles, measure edges to out_valid,
  // optionally stall the result, then hand it off.
  task automatic run_job(input string tag, input logic [W-1:0] bx0, input logic [W-1:0] bx1,
                         input logic [PW-1:0] pr, input logic [W-1:0] tl, input logic zmode,
                         input int exp_bz, input int exp_k, input int exp_lat, input int hold);
    int lat;
    Bxs      = {bx1, bx0};
    prec     = pr;
    tol      = tl;
    zm       = zmode;
    in_valid = 1'b1;
    chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    // c=0: threshold 0; c=1: threshold 128.
    chk({tag, ".xs_c0"}, 32'(Xs), 32'({bx1 > 8'd0, bx0 > 8'd0}));
    chk({tag, ".xcs_c0"}, 32'(Xcs), 32'd0);
    tick;
    lat = 1;
    chk({tag, ".xs_c1"}, 32'(Xs), 32'({bx1 > 8'd128, bx0 > 8'd128}));
    chk({tag, ".xcs_c1"}, 32'(Xcs), 32'd1);
    while (!out_valid && lat < 600) begin
      tick;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".bz"}, 32'(Bz), 32'(exp_bz));
    chk({tag, ".k"}, 32'(k_out), 32'(exp_k));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      tick;
      chk({tag, ".hold_ov"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_bz"}, 32'(Bz), 32'(exp_bz));
      chk({tag, ".hold_k"}, 32'(k_out), 32'(exp_k));
      chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, ".bz_keep"}, 32'(Bz), 32'(exp_bz));
    chk({tag, ".xs_idle"}, 32'(Xs), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Bxs       = '0;
    prec      = '0;
    tol       = '0;
    zm        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.bz", 32'(Bz), 32'd0);
    chk("rst.k", 32'(k_out), 32'd0);
    chk("rst.xs", 32'(Xs), 32'd0);
    chk("rst.xcs", 32'(Xcs), 32'd0);

    // AND of two 0.5 streams: r<128 in both, 128 ones over 256 cycles.
    run_job("and", 8'd128, 8'd128, 4'd8, 8'd0, 1'b0, 128, ET ? 2 : 8, ET ? 4 : 256, 0);
    // 0.25 operand: converges at k=3 (64 vs 64) with the check enabled.
    run_job("conv", 8'd64, 8'd0, 4'd8, 8'd0, 1'b1, 64, ET ? 3 : 8, ET ? 8 : 256, 0);
    // Near full scale plus a 10-cycle result stall with in_valid pulsing.
    run_job("full", 8'd255, 8'd0, 4'd8, 8'd0, 1'b1, ET ? 256 : 255, ET ? 2 : 8, ET ? 4 : 256, 10);
    // Precision clamps.
    run_job("clamp0", 8'd128, 8'd0, 4'd0, 8'd0, 1'b1, 128, 1, 2, 0);
    run_job("clamp15", 8'd128, 8'd0, 4'd15, 8'd0, 1'b1, 128, ET ? 2 : 8, ET ? 4 : 256, 0);

    // Reset in the middle of a job.
    Bxs      = {8'd128, 8'd128};
    prec     = 4'd8;
    zm       = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (RST_AT) tick;
    chk("mid.xs_pre", 32'(Xs), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid.ov", 32'(out_valid), 32'd0);
    chk("mid.xs", 32'(Xs), 32'd0);
    chk("mid.xcs", 32'(Xcs), 32'd0);
    chk("mid.bz", 32'(Bz), 32'd0);
    chk("mid.k", 32'(k_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    chk("mid.rdy", 32'(in_ready), 32'd1);
    run_job("post", 8'd128, 8'd0, 4'd8, 8'd0, 1'b1, 128, ET ? 2 : 8, ET ? 4 : 256, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
